egress_frame_serializer: RTL and testbench

EGRESS_FRAME_SERIALIZER -- requirements
Module: egress_frame_serializer

---
 rtl/egress_frame_serializer.sv | 203 ++++++++++++++++++++
 tb/tb_egress_frame_serializer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egress_frame_serializer.sv
// Store-and-forward egress buffer: 128-bit fabric words in, 32-bit MAC lanes out.
// A frame becomes visible to the reader only once its last word commits; overflowing frames are rewound.

module egress_frame_serializer #(
   parameter int DEPTH        = 128,
   parameter int FRAME_SLOTS  = 8,
   parameter int SPACE_THRESH = 96
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         frame_valid,
   input  logic         frame_last,
   input  logic [127:0] frame_data,
   input  logic [4:0]   frame_last_bytes,
   output logic         space_avail,
   input  logic         tx_ready,
   output logic         tx_start,
   output logic         tx_data_valid,
   output logic [2:0]   tx_bytes_valid,
   output logic [31:0]  tx_data,
   output logic [15:0]  drop_count,
   output logic [1:0]   fsm_state
);

   localparam int AW  = $clog2(DEPTH);
   localparam int SW  = $clog2(FRAME_SLOTS);
   localparam int AW1 = AW + 1;
   localparam int SW1 = SW + 1;
   localparam int LW  = AW + 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2
   } state_t;

   state_t         state;

   logic [127:0]   data_mem [DEPTH];
   logic [AW+5:0]  desc_mem [FRAME_SLOTS];

   logic [AW:0]    wr_spec;
   logic [AW:0]    wr_commit;
   logic [AW:0]    rd_ptr;
   logic [SW:0]    desc_wr;
   logic [SW:0]    desc_rd;
   logic           dropping;
   logic           init_done;

   logic [AW:0]    cur_words;
   logic [LW-1:0]  cur_lanes;
   logic [2:0]     cur_tail;
   logic [LW-1:0]  lane_cnt;

   logic [AW:0]    used_spec;
   logic           data_full;
   logic           desc_full;
   logic           desc_empty;
   logic           word_ok;
   logic           word_ovf;
   logic           drop_done;
   logic [AW:0]    frame_words;

   logic [AW+5:0]  desc_head;
   logic [AW:0]    head_words;
   logic [4:0]     head_last;
   logic [LW-1:0]  head_lanes;
   logic [2:0]     head_tail;
   logic [AW-1:0]  word_addr;
   logic [127:0]   rd_word;
   logic [31:0]    lane_data;
   logic           lane_final;
   logic           frame_done;

   assign fsm_state = state;

   // Fullness is judged against the speculative pointer so a frame in flight reserves its words.
   always_comb begin
      used_spec   = wr_spec - rd_ptr;
      data_full   = (used_spec == AW1'(DEPTH));
      desc_full   = ((desc_wr - desc_rd) == SW1'(FRAME_SLOTS));
      desc_empty  = (desc_wr == desc_rd);
      word_ok     = frame_valid && !dropping && !data_full && !(frame_last && desc_full);
      word_ovf    = frame_valid && !dropping && !word_ok;
      drop_done   = frame_valid && frame_last && (dropping || word_ovf);
      frame_words = wr_spec - wr_commit + AW1'(1);
   end

   always_ff @(posedge clk) begin
      if (word_ok) begin
         data_mem[wr_spec[AW-1:0]] <= frame_data;
      end
      if (word_ok && frame_last) begin
         desc_mem[desc_wr[SW-1:0]] <= {frame_words, frame_last_bytes};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_spec     <= '0;
         wr_commit   <= '0;
         desc_wr     <= '0;
         dropping    <= 1'b0;
         drop_count  <= '0;
         init_done   <= 1'b0;
         space_avail <= 1'b0;
      end else begin
         init_done   <= 1'b1;
         space_avail <= init_done && (used_spec <= AW1'(DEPTH - SPACE_THRESH)) && !desc_full;
         if (word_ok) begin
            wr_spec <= wr_spec + AW1'(1);
            if (frame_last) begin
               wr_commit <= wr_spec + AW1'(1);
               desc_wr   <= desc_wr + SW1'(1);
            end
         end else if (word_ovf) begin
            // Rewind now; keep swallowing words until the frame's last word arrives.
            wr_spec  <= wr_commit;
            dropping <= !frame_last;
         end else if (drop_done) begin
            dropping <= 1'b0;
         end
         if (drop_done && (drop_count != 16'hffff)) begin
            drop_count <= drop_count + 16'd1;
         end
      end
   end

   always_comb begin
      desc_head  = desc_mem[desc_rd[SW-1:0]];
      head_words = desc_head[AW+5:5];
      head_last  = desc_head[4:0];
      head_lanes = LW'({head_words - AW1'(1), 2'b00}) + LW'((head_last + 5'd3) >> 2);
      head_tail  = 3'((head_last - 5'd1) & 5'd3) + 3'd1;
      word_addr  = rd_ptr[AW-1:0] + lane_cnt[AW+1:2];
      rd_word    = data_mem[word_addr];
      case (lane_cnt[1:0])
         2'd0:    lane_data = rd_word[127:96];
         2'd1:    lane_data = rd_word[95:64];
         2'd2:    lane_data = rd_word[63:32];
         default: lane_data = rd_word[31:0];
      endcase
      lane_final = (lane_cnt == (cur_lanes - LW'(1)));
      frame_done = (lane_cnt == cur_lanes);
   end

   // Words of the frame being read stay resident until the final lane; the pop frees them all at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         rd_ptr         <= '0;
         desc_rd        <= '0;
         cur_words      <= '0;
         cur_lanes      <= '0;
         cur_tail       <= '0;
         lane_cnt       <= '0;
         tx_start       <= 1'b0;
         tx_data_valid  <= 1'b0;
         tx_bytes_valid <= '0;
         tx_data        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (tx_ready && !desc_empty) begin
                  state     <= START;
                  tx_start  <= 1'b1;
                  cur_words <= head_words;
                  cur_lanes <= head_lanes;
                  cur_tail  <= head_tail;
                  lane_cnt  <= '0;
               end
            end
            START: begin
               state          <= DATA;
               tx_start       <= 1'b0;
               tx_data_valid  <= 1'b1;
               tx_data        <= lane_data;
               tx_bytes_valid <= lane_final ? cur_tail : 3'd4;
               lane_cnt       <= lane_cnt + LW'(1);
            end
            DATA: begin
               if (frame_done) begin
                  state          <= IDLE;
                  tx_data_valid  <= 1'b0;
                  tx_bytes_valid <= '0;
                  tx_data        <= '0;
                  rd_ptr         <= rd_ptr + cur_words;
                  desc_rd        <= desc_rd + SW1'(1);
               end else begin
                  tx_data_valid  <= 1'b1;
                  tx_data        <= lane_data;
                  tx_bytes_valid <= lane_final ? cur_tail : 3'd4;
                  lane_cnt       <= lane_cnt + LW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_egress_frame_serializer.sv
// Bench for egress_frame_serializer: byte-level frame model feeds an expected-lane queue;
// table vectors, drop/reset sequences and randomized batches are checked against it.

module tb_egress_frame_serializer;

   localparam int W = 37;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         frame_valid = 1'b0;
   logic         frame_last = 1'b0;
   logic [127:0] frame_data = '0;
   logic [4:0]   frame_last_bytes = '0;
   logic         tx_ready = 1'b0;
   logic         space_avail;
   logic         tx_start;
   logic         tx_data_valid;
   logic [2:0]   tx_bytes_valid;
   logic [31:0]  tx_data;
   logic [15:0]  drop_count;
   logic [1:0]   fsm_state;

   egress_frame_serializer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .frame_valid      (frame_valid),
      .frame_last       (frame_last),
      .frame_data       (frame_data),
      .frame_last_bytes (frame_last_bytes),
      .space_avail      (space_avail),
      .tx_ready         (tx_ready),
      .tx_start         (tx_start),
      .tx_data_valid    (tx_data_valid),
      .tx_bytes_valid   (tx_bytes_valid),
      .tx_data          (tx_data),
      .drop_count       (drop_count),
      .fsm_state        (fsm_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard state ----------------
   // Entry layout: {last_lane, first_lane, bytes_valid[2:0], data[31:0]}
   logic [W-1:0] exp_q[$];
   int           n_checks = 0;
   int           n_fail = 0;
   int           exp_drops = 0;
   logic [7:0]   fb [0:2047];
   logic         rnd_ready_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name, input int act);
      n_checks++;
      n_fail++;
      $display("FAIL %s: observed %0d (t=%0t)", name, act, $time);
   endtask

   // ---------------- monitor ----------------
   logic        prev_start = 1'b0;
   logic        prev_valid = 1'b0;
   logic        in_frame = 1'b0;
   int          in_lanes = 0;
   logic [2:0]  last_bv = '0;
   logic [31:0] last_data = '0;
   int          frame_lanes = -1;
   logic [2:0]  frame_bv = '0;
   logic [31:0] frame_last_data = '0;
   int          frames_seen = 0;
   int          last_lane_cyc = -1000;
   int          start_gap = 0;

   always @(negedge clk) begin
      logic [W-1:0] e;
      if (!rst_n) begin
         prev_start = 1'b0;
         prev_valid = 1'b0;
         in_frame   = 1'b0;
         in_lanes   = 0;
      end else begin
         if (in_frame && !tx_data_valid) begin
            fail_now("lane_gap", in_lanes);
            in_frame = 1'b0;
         end
         if (tx_start) begin
            check("start_pulse_width", prev_start, 1'b0);
            frames_seen++;
            start_gap = cyc - last_lane_cyc;
            in_lanes  = 0;
         end
         if (tx_data_valid) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_lane", tx_data);
            end else begin
               e = exp_q.pop_front();
               check("lane", {prev_start, tx_bytes_valid, tx_data}, e[35:0]);
               in_frame = !e[36];
               if (e[36]) last_lane_cyc = cyc;
            end
            in_lanes++;
            last_bv   = tx_bytes_valid;
            last_data = tx_data;
         end else if (prev_valid) begin
            frame_lanes     = in_lanes;
            frame_bv        = last_bv;
            frame_last_data = last_data;
         end
         if (tx_start) in_frame = 1'b1;
         prev_start = tx_start;
         prev_valid = tx_data_valid;
      end
   end

   always @(negedge clk) begin
      if (rnd_ready_en) tx_ready = 1'($urandom_range(0, 1));
   end

   // ---------------- reference model ----------------
   task automatic fill_bytes(input int len);
      for (int i = 0; i < len; i++) fb[i] = 8'($urandom_range(0, 255));
   endtask

   // The MAC sees the frame as a plain byte stream cut into 4-byte lanes, first byte most significant.
   task automatic push_expected(input int len);
      int nl;
      int bv;
      logic [31:0] d;
      nl = (len + 3) / 4;
      for (int j = 0; j < nl; j++) begin
         bv = (len - 4 * j >= 4) ? 4 : len - 4 * j;
         d  = '0;
         for (int k = 0; k < bv; k++) d[31 - 8 * k -: 8] = fb[4 * j + k];
         exp_q.push_back({(j == nl - 1), (j == 0), 3'(bv), d});
      end
   endtask

   // ---------------- drivers ----------------
   task automatic send_frame(input int len, input int max_gap);
      int nw;
      int idx;
      nw = (len + 15) / 16;
      for (int w = 0; w < nw; w++) begin
         int gap;
         gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            frame_valid = 1'b0;
            frame_last  = 1'b0;
         end
         @(negedge clk);
         frame_valid = 1'b1;
         frame_last  = (w == nw - 1);
         for (int b = 0; b < 16; b++) begin
            idx = w * 16 + b;
            frame_data[127 - 8 * b -: 8] = (idx < len) ? fb[idx] : 8'h00;
         end
         frame_last_bytes = (w == nw - 1) ? 5'(len - 16 * (nw - 1)) : 5'($urandom_range(0, 31));
      end
   endtask

   task automatic fabric_idle();
      @(negedge clk);
      frame_valid = 1'b0;
      frame_last  = 1'b0;
      frame_data  = '0;
   endtask

   task automatic wait_drain(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         if (exp_q.size() == 0 && !tx_data_valid) break;
         @(negedge clk);
      end
      if (i == budget) begin
         fail_now("drain_timeout", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      exp_drops = 0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      int len;
      int exp_lanes;
      int exp_bv;
      int tail_idx;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int snap;
      int nf;
      int used;

      vecs[0] = '{64, 16, 4, 60};
      vecs[1] = '{61, 16, 1, 60};
      vecs[2] = '{1, 1, 1, 0};
      vecs[3] = '{16, 4, 4, 12};
      vecs[4] = '{17, 5, 1, 16};
      vecs[5] = '{30, 8, 2, 28};
      vecs[6] = '{47, 12, 3, 44};
      vecs[7] = '{100, 25, 4, 96};

      // Reset values and space_avail release latency
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx_start", tx_start, 1'b0);
      check("rst_tx_data_valid", tx_data_valid, 1'b0);
      check("rst_tx_bytes_valid", tx_bytes_valid, 3'd0);
      check("rst_tx_data", tx_data, 32'h0);
      check("rst_drop_count", drop_count, 16'h0);
      check("rst_space_avail", space_avail, 1'b0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("space_avail_cycle1", space_avail, 1'b0);
      @(negedge clk);
      check("space_avail_cycle2", space_avail, 1'b1);

      // Single frames, one per table row
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         frame_lanes = -1;
         fill_bytes(vecs[i].len);
         push_expected(vecs[i].len);
         send_frame(vecs[i].len, 0);
         fabric_idle();
         wait_drain(400);
         check("vec_lanes", frame_lanes, vecs[i].exp_lanes);
         check("vec_final_bv", frame_bv, vecs[i].exp_bv);
         check("vec_tail_byte", frame_last_data[31:24], fb[vecs[i].tail_idx]);
      end

      // Two frames back to back on the fabric
      snap = frames_seen;
      fill_bytes(64);
      push_expected(64);
      send_frame(64, 0);
      fill_bytes(30);
      push_expected(30);
      send_frame(30, 0);
      fabric_idle();
      wait_drain(400);
      check("b2b_frames", frames_seen - snap, 2);
      check("b2b_start_gap", start_gap, 2);
      check("b2b_space_avail", space_avail, 1'b1);

      // Descriptor FIFO overflow: ninth frame dropped while MAC holds off
      tx_ready = 1'b0;
      snap = frames_seen;
      for (int i = 0; i < 8; i++) begin
         int len;
         len = $urandom_range(1, 48);
         fill_bytes(len);
         push_expected(len);
         send_frame(len, 1);
      end
      fill_bytes(20);
      send_frame(20, 0);
      exp_drops++;
      fabric_idle();
      repeat (3) @(negedge clk);
      check("desc_ovf_drop_count", drop_count, 16'(exp_drops));
      check("desc_ovf_space_avail", space_avail, 1'b0);
      check("desc_ovf_no_tx", frames_seen - snap, 0);
      tx_ready = 1'b1;
      wait_drain(600);
      check("desc_ovf_frames", frames_seen - snap, 8);
      check("desc_ovf_space_after", space_avail, 1'b1);

      // Data FIFO overflow: 1518-byte frame on top of 40 resident words
      tx_ready = 1'b0;
      snap = frames_seen;
      for (int i = 0; i < 4; i++) begin
         fill_bytes(160);
         push_expected(160);
         send_frame(160, 0);
      end
      fill_bytes(1518);
      send_frame(1518, 0);
      exp_drops++;
      fabric_idle();
      repeat (3) @(negedge clk);
      check("data_ovf_drop_count", drop_count, 16'(exp_drops));
      check("data_ovf_space_avail", space_avail, 1'b0);
      fill_bytes(32);
      push_expected(32);
      send_frame(32, 0);
      fabric_idle();
      tx_ready = 1'b1;
      wait_drain(800);
      check("data_ovf_frames", frames_seen - snap, 5);
      check("data_ovf_drop_hold", drop_count, 16'(exp_drops));

      // Reset while the reader is mid-frame
      snap = frames_seen;
      tx_ready = 1'b1;
      fill_bytes(64);
      push_expected(64);
      send_frame(64, 0);
      fabric_idle();
      begin
         int i;
         for (i = 0; i < 200; i++) begin
            if (frames_seen > snap && in_lanes >= 5) break;
            @(negedge clk);
         end
         if (i == 200) fail_now("reset_wait_timeout", in_lanes);
      end
      #2 rst_n = 1'b0;
      #1;
      check("midrst_tx_start", tx_start, 1'b0);
      check("midrst_tx_data_valid", tx_data_valid, 1'b0);
      check("midrst_tx_bytes_valid", tx_bytes_valid, 3'd0);
      check("midrst_tx_data", tx_data, 32'h0);
      exp_q.delete();
      exp_drops = 0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      snap = frames_seen;
      @(negedge clk);
      check("midrst_space_cycle1", space_avail, 1'b0);
      @(negedge clk);
      check("midrst_space_cycle2", space_avail, 1'b1);
      check("midrst_drop_count", drop_count, 16'h0);
      repeat (40) @(negedge clk);
      check("midrst_no_frames", frames_seen - snap, 0);

      // Randomized batches that always fit, with random MAC readiness and fabric gaps
      for (int b = 0; b < 6; b++) begin
         nf   = int'($urandom_range(1, 8));
         used = 0;
         snap = frames_seen;
         rnd_ready_en = 1'b1;
         for (int f = 0; f < nf; f++) begin
            int len;
            len = int'($urandom_range(1, 256));
            if (len > (128 - used) * 16) len = (128 - used) * 16;
            if (len == 0) begin
               nf = f;
               break;
            end
            used += (len + 15) / 16;
            fill_bytes(len);
            push_expected(len);
            send_frame(len, 2);
         end
         fabric_idle();
         wait_drain(6000);
         rnd_ready_en = 1'b0;
         tx_ready = 1'b1;
         repeat (4) @(negedge clk);
         check("rand_frames", frames_seen - snap, nf);
         check("rand_drop_count", drop_count, 16'(exp_drops));
      end
      check("final_space_avail", space_avail, 1'b1);
      check("final_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
